cursor_controller: RTL

CURSOR_CONTROLLER -- requirements
Module: cursor_controller

---
 rtl/cursor_controller.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/cursor_controller.sv
// Chess-board cursor and square-selection controller: debounced keys move the cursor; the lock switch selects and commits a move.
// Optional auto-repeat of a held direction key is compiled in with CURSOR_AUTOREPEAT_EN.
module cursor_controller #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_CYCLES   = 12500000
) (
  input  logic       clock,
  input  logic       globalReset_n,
  input  logic       KeyLeft,
  input  logic       KeyUp,
  input  logic       KeyDown,
  input  logic       KeyRight,
  input  logic       LockSwitch,
  input  logic       enable,
  output logic [2:0] cursorX,
  output logic [2:0] cursorY,
  output logic       selValid,
  output logic [2:0] selX,
  output logic [2:0] selY,
  output logic       moveValid,
  output logic [2:0] moveFromX,
  output logic [2:0] moveFromY,
  output logic [2:0] moveToX,
  output logic [2:0] moveToY,
  input  logic       moveReady
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int NI = 5;
  // Bit order doubles as key priority: left, right, up, down; bit 4 is the lock switch.
  localparam logic [NI-1:0] RST_VAL = 5'b0_1111;

  typedef enum logic [1:0] {IDLE, SELECTED, REQUEST} state_t;

  logic [NI-1:0] raw, sync1_q, sync2_q;
  logic [NI-1:0] deb_q, deb_d, prev_q, prev_d;
  logic [CW-1:0] cnt_q [NI];
  logic [CW-1:0] cnt_d [NI];
  logic [CW-1:0] settle_q, settle_d;
  logic          settling;
  logic [3:0]    fall, rep_pulse, press;
  logic          lock_ev;

  state_t     state_q, state_d;
  logic [2:0] cur_x_q, cur_x_d, cur_y_q, cur_y_d;
  logic [2:0] sel_x_q, sel_x_d, sel_y_q, sel_y_d;
  logic [2:0] from_x_q, from_x_d, from_y_q, from_y_d;
  logic [2:0] to_x_q, to_x_d, to_y_q, to_y_d;

  assign raw = {LockSwitch, KeyDown, KeyUp, KeyRight, KeyLeft};

  always_ff @(posedge clock or negedge globalReset_n) begin
    if (!globalReset_n) begin
      sync1_q <= RST_VAL;
      sync2_q <= RST_VAL;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
    end
  end

  assign settling = (settle_q != CW'(DEBOUNCE_CYCLES));

  // While settling, the lock state follows its input and edge history is kept equal to it so no event can leak out.
  always_comb begin
    settle_d = settling ? settle_q + CW'(1) : settle_q;
    for (int i = 0; i < NI; i++) begin
      deb_d[i] = deb_q[i];
      cnt_d[i] = '0;
      if (settling && i == NI - 1) begin
        deb_d[i] = sync2_q[i];
      end else if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == CW'(DEBOUNCE_CYCLES - 1)) deb_d[i] = sync2_q[i];
        else cnt_d[i] = cnt_q[i] + CW'(1);
      end
      prev_d[i] = settling ? deb_d[i] : deb_q[i];
    end
  end

  always_ff @(posedge clock or negedge globalReset_n) begin
    if (!globalReset_n) begin
      deb_q    <= RST_VAL;
      prev_q   <= RST_VAL;
      settle_q <= '0;
      for (int i = 0; i < NI; i++) cnt_q[i] <= '0;
    end else begin
      deb_q    <= deb_d;
      prev_q   <= prev_d;
      settle_q <= settle_d;
      for (int i = 0; i < NI; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign fall = prev_q[3:0] & ~deb_q[3:0];

`ifdef CURSOR_AUTOREPEAT_EN
  localparam int RW = $clog2(REPEAT_CYCLES + 1);
  logic [RW-1:0] rep_q, rep_d;
  logic [3:0]    held, top_held;

  assign held     = ~deb_q[3:0];
  assign top_held = held & (~held + 4'd1);

  // The repeat period restarts on every fresh press and only the top-priority held key repeats.
  always_comb begin
    rep_d     = rep_q + RW'(1);
    rep_pulse = '0;
    if (settling || held == 4'd0 || fall != 4'd0) begin
      rep_d = '0;
    end else if (rep_q == RW'(REPEAT_CYCLES - 1)) begin
      rep_pulse = top_held;
      rep_d     = '0;
    end
  end

  always_ff @(posedge clock or negedge globalReset_n) begin
    if (!globalReset_n) rep_q <= '0;
    else rep_q <= rep_d;
  end
`else
  if (REPEAT_CYCLES < 0) begin : g_no_repeat
  end
  assign rep_pulse = 4'd0;
`endif

  assign press   = (fall | rep_pulse) & {4{enable & ~settling}};
  assign lock_ev = (prev_q[4] ^ deb_q[4]) & enable & ~settling;

  // The FSM looks only at the registered cursor, so a same-cycle press moves the cursor after selection.
  always_comb begin
    state_d  = state_q;
    cur_x_d  = cur_x_q;
    cur_y_d  = cur_y_q;
    sel_x_d  = sel_x_q;
    sel_y_d  = sel_y_q;
    from_x_d = from_x_q;
    from_y_d = from_y_q;
    to_x_d   = to_x_q;
    to_y_d   = to_y_q;
    if (state_q != REQUEST) begin
      if (press[0])      cur_x_d = cur_x_q - 3'd1;
      else if (press[1]) cur_x_d = cur_x_q + 3'd1;
      else if (press[2]) cur_y_d = cur_y_q - 3'd1;
      else if (press[3]) cur_y_d = cur_y_q + 3'd1;
    end
    case (state_q)
      IDLE: begin
        if (lock_ev) begin
          sel_x_d = cur_x_q;
          sel_y_d = cur_y_q;
          state_d = SELECTED;
        end
      end
      SELECTED: begin
        if (lock_ev) begin
          if (cur_x_q == sel_x_q && cur_y_q == sel_y_q) begin
            state_d = IDLE;
          end else begin
            from_x_d = sel_x_q;
            from_y_d = sel_y_q;
            to_x_d   = cur_x_q;
            to_y_d   = cur_y_q;
            state_d  = REQUEST;
          end
        end
      end
      REQUEST: begin
        if (moveReady) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge globalReset_n) begin
    if (!globalReset_n) begin
      state_q  <= IDLE;
      cur_x_q  <= '0;
      cur_y_q  <= '0;
      sel_x_q  <= '0;
      sel_y_q  <= '0;
      from_x_q <= '0;
      from_y_q <= '0;
      to_x_q   <= '0;
      to_y_q   <= '0;
    end else begin
      state_q  <= state_d;
      cur_x_q  <= cur_x_d;
      cur_y_q  <= cur_y_d;
      sel_x_q  <= sel_x_d;
      sel_y_q  <= sel_y_d;
      from_x_q <= from_x_d;
      from_y_q <= from_y_d;
      to_x_q   <= to_x_d;
      to_y_q   <= to_y_d;
    end
  end

  assign cursorX   = cur_x_q;
  assign cursorY   = cur_y_q;
  assign selValid  = (state_q != IDLE);
  assign selX      = sel_x_q;
  assign selY      = sel_y_q;
  assign moveValid = (state_q == REQUEST);
  assign moveFromX = from_x_q;
  assign moveFromY = from_y_q;
  assign moveToX   = to_x_q;
  assign moveToY   = to_y_q;

endmodule
